// File: rtl/score_bcd_pkg.sv
// Shared score/display constants and conversion FSM encodings.
package score_bcd_pkg;

    localparam int unsigned SCORE_W       = 14;
    localparam int unsigned BCD_DIGITS    = 4;
    localparam int unsigned BCD_W         = 4 * BCD_DIGITS;
    localparam int unsigned MAX_SCORE     = 9999;
    localparam int unsigned POINTS_PELLET = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/score_bcd_bin2bcd_seq.sv
// Sequential double-dabble binary to packed-BCD converter, one shift per cycle.
module bin2bcd_seq
    import score_bcd_pkg::*;
#(
    parameter int unsigned BIN_W = SCORE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd_c,
    output logic             done_c,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned SR_W  = BCD_W + BIN_W;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_nxt;
    logic [SR_W-1:0]  sr_adj;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             busy_nxt;

    // Add-3 correction on every BCD nibble that would overflow after the shift
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            if (sr[BIN_W + 4*d +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    sr_nxt    = {{BCD_W{1'b0}}, bin};
                    cnt_nxt   = CNT_W'(BIN_W);
                    busy_nxt  = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_nxt  = sr_adj << 1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_c    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bcd_c = sr[SR_W-1 -: BCD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else begin
            sr   <= sr_nxt;
            cnt  <= cnt_nxt;
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/score_bcd.sv
// Pellet-event score accumulator with saturation, feeding a stable BCD value to the display.
module score_bcd #(
    parameter int unsigned POINTS    = score_bcd_pkg::POINTS_PELLET,
    parameter int unsigned MAX_SCORE = score_bcd_pkg::MAX_SCORE,
    parameter int unsigned SCORE_W   = score_bcd_pkg::SCORE_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            eat,
    input  logic                            clear,
    output logic [SCORE_W-1:0]              score_bin,
    output logic [score_bcd_pkg::BCD_W-1:0] bcd,
    output logic                            bcd_update,
    output logic                            busy
);

    import score_bcd_pkg::*;

    localparam int unsigned SUM_W = SCORE_W + 1;

    logic             eat_q;
    logic             ev;
    logic             pending;
    logic             pending_nxt;
    logic             start;
    logic [SUM_W-1:0] sum;
    logic [SCORE_W-1:0] score_nxt;
    logic [BCD_W-1:0] conv_bcd_c;
    logic             conv_done_c;

    // Edge detect, saturating accumulate, and re-conversion request
    always_comb begin
        ev        = eat & ~eat_q;
        sum       = SUM_W'(score_bin) + SUM_W'(POINTS);
        score_nxt = score_bin;
        if (clear) begin
            score_nxt = '0;
        end else if (ev) begin
            score_nxt = (sum > SUM_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
        end
        start       = pending & ~busy;
        pending_nxt = pending;
        // A fresh score change always wins over a conversion start on the same edge
        if (score_nxt != score_bin) begin
            pending_nxt = 1'b1;
        end else if (start) begin
            pending_nxt = 1'b0;
        end
    end

    bin2bcd_seq #(
        .BIN_W (SCORE_W)
    ) u_bin2bcd (
        .clk    (clk),
        .rst_n  (reset),
        .start  (start),
        .bin    (score_bin),
        .bcd_c  (conv_bcd_c),
        .done_c (conv_done_c),
        .busy   (busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eat_q      <= 1'b0;
            score_bin  <= '0;
            pending    <= 1'b0;
            bcd        <= '0;
            bcd_update <= 1'b0;
        end else begin
            eat_q      <= eat;
            score_bin  <= score_nxt;
            pending    <= pending_nxt;
            bcd_update <= conv_done_c;
            if (conv_done_c) begin
                bcd <= conv_bcd_c;
            end
        end
    end

endmodule
